alu_seq_comparator: RTL and testbench
=====================================

// Module: alu_seq_comparator
// PURPOSE
// - Parametrised, multi-cycle magnitude comparator for the RV32IM ALU/branch path.
// - Successor to the single-cycle signed comparator. Adds a signed/unsigned mode selected
//   by funct3, branch-condition and SLT/SLTU results, and valid/ready handshakes.
// - Compares CHUNK_WIDTH bits per cycle, MSB chunk first, and terminates early on the
//   first chunk that differs. Sits between operand fetch and the branch unit / ALU writeback.
// PARAMETERS
// - DATA_WIDTH   32  operand width; must be an integer multiple of CHUNK_WIDTH.
// - CHUNK_WIDTH  8   bits compared per cycle; CHUNK_WIDTH==DATA_WIDTH gives a 1-cycle scan.
// - NUM_CHUNKS   DATA_WIDTH/CHUNK_WIDTH  derived localparam; not overridable.
// PORTS
// - clk          in   1           single clock; all state updates on the rising edge.
// - rst          in   1           synchronous, active-high reset.
// - in_valid     in   1           operands and funct3 are valid.
// - in_ready     out  1           block can accept; high only in IDLE.
// - operand_a    in   DATA_WIDTH  rs1 value.
// - operand_b    in   DATA_WIDTH  rs2 or immediate value.
// - funct3       in   3           000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU,
//                                 010 SLT, 011 SLTU.
// - out_valid    out  1           result valid; held until out_ready.
// - out_ready    in   1           consumer accepts the result.
// - greater      out  1           a>b in the selected signedness.
// - equal        out  1           a==b.
// - less         out  1           a<b in the selected signedness.
// - cond_taken   out  1           funct3 condition true. SLT/SLTU: equals less.
// - slt_result   out  DATA_WIDTH  {DATA_WIDTH-1 zeros, less}.
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=0 during reset and 1 the cycle after.
//   out_valid, greater, equal, less, cond_taken=0; slt_result=0.
// - Signedness: unsigned for funct3 in {011,110,111}; signed otherwise.
//   Signed compare is done by inverting the MSB of both operands at capture, then
//   comparing unsigned.
// - FSM IDLE: in_ready=1. On in_valid&&in_ready, register operands, funct3 and
//   idx=NUM_CHUNKS-1, then go to SCAN.
// - FSM SCAN: in_ready=0. Compare chunk[idx] of a and b.
//   - Chunks differ: set greater/less, equal=0, go to DONE.
//   - Chunks equal and idx==0: set equal=1, go to DONE.
//   - Otherwise: idx decrements.
// - FSM DONE: out_valid=1 and all result outputs held stable. On out_ready, go to IDLE
//   and clear out_valid in the same edge.
// - Latency: out_valid rises n cycles after the accept edge, where n = chunks examined
//   (1..NUM_CHUNKS). Equal operands take NUM_CHUNKS cycles. No overlap: the next accept
//   happens at the earliest 1 cycle after the out handshake.
// - Exactly one of greater/equal/less is 1 whenever out_valid=1.
// - in_valid while busy is ignored; upstream holds its request until in_ready.
// - Reset in SCAN or DONE aborts the operation: the result is discarded and the FSM returns
//   to IDLE with reset values.
// - out_ready while out_valid=0 has no effect. Inputs are sampled only at the accept edge;
//   later changes do not affect the result in flight.
// CONFIGURATION
// - Macro CMP_MINMAX_EN.
//   - Defined: adds min_result and max_result (out, DATA_WIDTH). They carry the original,
//     uninverted operands, ordered in the selected signedness, and are valid with out_valid.
//   - On equal operands both outputs = operand_a. Reset value 0.
//   - Undefined: the ports and the registers behind them do not exist; all other
//     behaviour is identical.
// TESTING (DATA_WIDTH=32, CHUNK_WIDTH=8, out_ready=1 unless stated)
// - a=5, b=5, BEQ -> equal=1, cond_taken=1, out_valid 4 cycles after accept.
// - a=32'hFFFF_FFFF, b=1:
//   - BLT  -> less=1, cond_taken=1, 1 cycle.
//   - BLTU -> greater=1, cond_taken=0, 1 cycle.
// - a=32'h1234_5678, b=32'h1234_5679, SLTU -> less=1, slt_result=32'h1, 4 cycles.
// - a=32'h8000_0000, b=32'h7FFF_FFFF, BGE -> less=1, cond_taken=0.
// - Backpressure: out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0;
//   accept completes on the 4th cycle.
// - rst=1 for 1 cycle during SCAN (2nd chunk) -> IDLE, out_valid never asserts;
//   new request completes normally.
// - CMP_MINMAX_EN, a=-3, b=2:
//   - SLT  -> min_result=-3, max_result=2.
//   - SLTU -> min_result=2, max_result=32'hFFFF_FFFD.

Source files
------------

// File: rtl/alu_seq_comparator.sv
// -----------------------------------------------------------------------------
// alu_seq_comparator
//
// Multi-cycle magnitude comparator for the RV32IM branch / SLT path. It scans
// the operands CHUNK_WIDTH bits per cycle, starting with the most significant
// chunk, and stops at the first chunk that differs.
//
// Signed compares flip the MSB of both operands when they are captured. After
// that, a plain unsigned scan gives the correct ordering.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The producer holds valid and its data stable until that
// edge. Once a result is valid, it stays valid and stable until it is taken.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready is high only in IDLE)
//   operand_a, operand_b  rs1 and rs2/immediate
//   funct3                branch / SLT selector, also selects signedness
//   out_valid / out_ready result handshake
//   greater, equal, less  ordering of a vs b (exactly one is set when valid)
//   cond_taken            funct3 condition result
//   slt_result            {0..0, less}
//   min_result,max_result (only with CMP_MINMAX_EN) operands in order
//   dbg_state             current FSM state, for observation
//
// Configuration macro: CMP_MINMAX_EN adds min_result / max_result.
// -----------------------------------------------------------------------------
module alu_seq_comparator #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [2:0]            funct3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  greater,
    output logic                  equal,
    output logic                  less,
    output logic                  cond_taken,
    output logic [DATA_WIDTH-1:0] slt_result,
`ifdef CMP_MINMAX_EN
    output logic [DATA_WIDTH-1:0] min_result,
    output logic [DATA_WIDTH-1:0] max_result,
`endif
    output logic [1:0]            dbg_state
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   a_q;    // MSB flipped for signed modes
    logic [DATA_WIDTH-1:0]   b_q;
    logic [2:0]              f3_q;
`ifdef CMP_MINMAX_EN
    logic [DATA_WIDTH-1:0]   orig_a;
    logic [DATA_WIDTH-1:0]   orig_b;
`endif

    logic [CHUNK_WIDTH-1:0]  chunk_a;
    logic [CHUNK_WIDTH-1:0]  chunk_b;
    logic                    in_unsigned;
    logic [DATA_WIDTH-1:0]   sign_flip;

    assign dbg_state  = state;
    assign slt_result = {{(DATA_WIDTH-1){1'b0}}, less};

    always_comb begin
        chunk_a     = a_q[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_b     = b_q[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
        in_unsigned = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        sign_flip   = {~in_unsigned, {(DATA_WIDTH-1){1'b0}}};
    end

    // Branch / SLT condition from the final ordering.
    function automatic logic cond_of(input logic [2:0] f3, input logic e, input logic l);
        case (f3)
            3'b000:  cond_of = e;     // BEQ
            3'b001:  cond_of = ~e;    // BNE
            3'b101,
            3'b111:  cond_of = ~l;    // BGE, BGEU
            default: cond_of = l;     // BLT, BLTU, SLT, SLTU
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            greater    <= 1'b0;
            equal      <= 1'b0;
            less       <= 1'b0;
            cond_taken <= 1'b0;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            f3_q       <= '0;
`ifdef CMP_MINMAX_EN
            orig_a     <= '0;
            orig_b     <= '0;
            min_result <= '0;
            max_result <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= operand_a ^ sign_flip;
                        b_q      <= operand_b ^ sign_flip;
                        f3_q     <= funct3;
                        idx      <= IDX_W'(NUM_CHUNKS - 1);
                        in_ready <= 1'b0;
                        state    <= SCAN;
`ifdef CMP_MINMAX_EN
                        orig_a   <= operand_a;
                        orig_b   <= operand_b;
`endif
                    end
                end

                SCAN: begin
                    if (chunk_a != chunk_b) begin
                        greater    <= (chunk_a > chunk_b);
                        less       <= (chunk_a < chunk_b);
                        equal      <= 1'b0;
                        cond_taken <= cond_of(f3_q, 1'b0, chunk_a < chunk_b);
`ifdef CMP_MINMAX_EN
                        min_result <= (chunk_a < chunk_b) ? orig_a : orig_b;
                        max_result <= (chunk_a < chunk_b) ? orig_b : orig_a;
`endif
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (idx == '0) begin
                        greater    <= 1'b0;
                        less       <= 1'b0;
                        equal      <= 1'b1;
                        cond_taken <= cond_of(f3_q, 1'b1, 1'b0);
`ifdef CMP_MINMAX_EN
                        min_result <= orig_a;
                        max_result <= orig_a;
`endif
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_comparator.sv
module tb_alu_seq_comparator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic        greater;
    logic        equal;
    logic        less;
    logic        cond_taken;
    logic [31:0] slt_result;
`ifdef CMP_MINMAX_EN
    logic [31:0] min_result;
    logic [31:0] max_result;
`endif
    logic [1:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    alu_seq_comparator #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .funct3     (funct3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .greater    (greater),
        .equal      (equal),
        .less       (less),
        .cond_taken (cond_taken),
        .slt_result (slt_result),
`ifdef CMP_MINMAX_EN
        .min_result (min_result),
        .max_result (max_result),
`endif
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for out_valid; lat = cycles after the accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, output int lat);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        chk("ready_before_req", in_ready, 1);
        operand_a = a;
        operand_b = b;
        funct3    = f3;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; the result must not change.
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        funct3    = 3'($urandom_range(0, 7));
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic do_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input int exp_lat,
                           input logic eg, input logic ee, input logic el, input logic ec);
        int lat;
        run_op(a, b, f3, lat);
        chk({tag, "_lat"},     64'(lat), 64'(exp_lat));
        chk({tag, "_greater"}, greater, eg);
        chk({tag, "_equal"},   equal, ee);
        chk({tag, "_less"},    less, el);
        chk({tag, "_cond"},    cond_taken, ec);
        chk({tag, "_slt"},     slt_result, {31'd0, el});
        chk({tag, "_busy"},    in_ready, 0);
        @(posedge clk); #1;   // out_ready=1 -> handshake
        chk({tag, "_drop"},    out_valid, 0);
        chk({tag, "_idle"},    in_ready, 1);
    endtask

    initial begin
        int  lat;
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        funct3    = '0;
        out_ready = 1'b1;

        // reset state
        @(posedge clk); #1;
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_results",   {greater, equal, less, cond_taken}, 0);
        chk("rst_slt",       slt_result, 0);
        chk("rst_state",     dbg_state, 0);
`ifdef CMP_MINMAX_EN
        chk("rst_min", min_result, 0);
        chk("rst_max", max_result, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1);

        // directed vectors                 a             b             f3     lat g  e  l  cond
        do_case("beq_eq",    32'd5,        32'd5,        3'b000, 4, 0, 1, 0, 1);
        do_case("bne_eq",    32'd5,        32'd5,        3'b001, 4, 0, 1, 0, 0);
        do_case("blt_m1",    32'hFFFF_FFFF, 32'd1,       3'b100, 1, 0, 0, 1, 1);
        do_case("bltu_m1",   32'hFFFF_FFFF, 32'd1,       3'b110, 1, 1, 0, 0, 0);
        do_case("sltu_lsb",  32'h1234_5678, 32'h1234_5679, 3'b011, 4, 0, 0, 1, 1);
        do_case("bge_min",   32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1, 0, 0, 1, 0);
        do_case("bgeu_ch2",  32'h0001_0000, 32'h0000_FFFF, 3'b111, 2, 1, 0, 0, 1);
        do_case("bne_ch1",   32'h0000_0200, 32'h0000_0100, 3'b001, 3, 1, 0, 0, 1);
        do_case("slt_pos",   32'd2,        32'hFFFF_FFFD, 3'b010, 1, 1, 0, 0, 0);

        // backpressure: hold out_ready low for 3 cycles in DONE
        out_ready = 1'b0;
        run_op(32'd7, 32'd9, 3'b110, lat);
        chk("bp_lat",  64'(lat), 4);
        chk("bp_less", less, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_res",   {greater, equal, less, cond_taken}, 4'b0011);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", out_valid, 0);
        chk("bp_idle",    in_ready, 1);

        // reset while scanning the second chunk
        operand_a = 32'hABCD_0001;
        operand_b = 32'hABCD_0001;
        funct3    = 3'b000;
        in_valid  = 1'b1;
        @(posedge clk); #1;      // accept
        in_valid = 1'b0;
        @(posedge clk); #1;      // chunk 3 compared, chunk 2 next
        chk("abort_scanning", dbg_state, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", dbg_state, 0);
        chk("abort_ready", in_ready, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", seen, 0);
        do_case("after_abort", 32'd3, 32'd4, 3'b100, 4, 0, 0, 1, 1);

`ifdef CMP_MINMAX_EN
        run_op(32'hFFFF_FFFD, 32'd2, 3'b010, lat);
        chk("mm_slt_min", min_result, 32'hFFFF_FFFD);
        chk("mm_slt_max", max_result, 32'd2);
        @(posedge clk); #1;
        run_op(32'hFFFF_FFFD, 32'd2, 3'b011, lat);
        chk("mm_sltu_min", min_result, 32'd2);
        chk("mm_sltu_max", max_result, 32'hFFFF_FFFD);
        @(posedge clk); #1;
        run_op(32'd6, 32'd6, 3'b000, lat);
        chk("mm_eq_min", min_result, 32'd6);
        chk("mm_eq_max", max_result, 32'd6);
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound in case a wait loop is miswritten.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
